// File: rtl/task_scheduler.sv
// Central task FIFO shared by NUM_CORES cores: per-core 1-deep push holds, round-robin
// drain and dispatch, start-PC hand-off and global completion detection.
module task_scheduler #(
   parameter int unsigned NUM_CORES   = 4,
   parameter int unsigned QUEUE_DEPTH = 16,
   parameter int unsigned QN_W        = 4,
   parameter int unsigned PC_W        = 16,
   parameter int unsigned PC_SHIFT    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CORES-1:0]          request_new_pc,
   input  logic [NUM_CORES-1:0]          queue_wen,
   input  logic [NUM_CORES*QN_W-1:0]     queue_number,
   output logic [NUM_CORES*PC_W-1:0]     new_pc,
   output logic [NUM_CORES-1:0]          pc_valid,
   output logic [NUM_CORES*2-1:0]        idle,
   output logic                          done,
   output logic                          overflow,
   output logic [$clog2(QUEUE_DEPTH):0]  task_count
);

   localparam int unsigned AW = $clog2(QUEUE_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {StRun = 2'b00, StWait = 2'b01, StDone = 2'b10} state_e;

   state_e               r_state   [NUM_CORES];
   state_e               w_state_d [NUM_CORES];
   logic [NUM_CORES-1:0] r_hold_vld;
   logic [QN_W-1:0]      r_hold_id [NUM_CORES];
   logic [QN_W-1:0]      r_mem     [QUEUE_DEPTH];
   logic [AW-1:0]        r_head;
   logic [AW-1:0]        r_tail;
   logic [CW-1:0]        r_count;
   logic [PW-1:0]        r_push_ptr;
   logic [PW-1:0]        r_disp_ptr;
   logic [PC_W-1:0]      r_new_pc  [NUM_CORES];
   logic [NUM_CORES-1:0] r_pc_valid;
   logic                 r_done;
   logic                 r_overflow;

   logic [NUM_CORES-1:0] w_wait;
   logic [PW:0]          w_pop_pick;
   logic [PW:0]          w_drn_pick;
   logic [PW-1:0]        w_pop_idx;
   logic [PW-1:0]        w_drn_idx;
   logic                 w_pop;
   logic                 w_drain;
   logic                 w_all_done;
   logic [PC_W-1:0]      w_start_pc;

   // Returns {found, index} of the first set request at or after ptr, wrapping.
   function automatic logic [PW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                           input logic [PW-1:0] ptr);
      logic [PW:0] res;
      int unsigned idx;
      res = '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         idx = (32'(ptr) + k) % NUM_CORES;
         if (!res[PW] && req[idx]) res = {1'b1, PW'(idx)};
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
      return (32'(idx) == NUM_CORES - 1) ? '0 : idx + PW'(1);
   endfunction

   always_comb begin
      w_wait = '0;
      for (int i = 0; i < NUM_CORES; i++) w_wait[i] = (r_state[i] == StWait);
   end

   assign w_pop_pick = rr_pick(w_wait, r_disp_ptr);
   assign w_drn_pick = rr_pick(r_hold_vld, r_push_ptr);
   assign w_pop_idx  = w_pop_pick[PW-1:0];
   assign w_drn_idx  = w_drn_pick[PW-1:0];
   assign w_pop      = w_pop_pick[PW] && (r_count != '0);
   // A full FIFO still accepts a drain when the same edge pops an entry.
   assign w_drain    = w_drn_pick[PW] && ((r_count < CW'(QUEUE_DEPTH)) || w_pop);
   assign w_all_done = (&w_wait) && (r_count == '0) && !(|r_hold_vld) && !(|queue_wen);
   assign w_start_pc = PC_W'(r_mem[r_head]) << PC_SHIFT;

   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         w_state_d[i] = r_state[i];
         unique case (r_state[i])
            StRun:  if (request_new_pc[i]) w_state_d[i] = StWait;
            StWait: begin
               if (w_all_done)                            w_state_d[i] = StDone;
               else if (w_pop && (w_pop_idx == PW'(i)))   w_state_d[i] = StRun;
            end
            StDone: w_state_d[i] = StDone;
            default: w_state_d[i] = r_state[i];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            r_state[i]   <= StWait;
            r_hold_id[i] <= '0;
            r_new_pc[i]  <= '0;
         end
         for (int j = 0; j < QUEUE_DEPTH; j++) r_mem[j] <= '0;
         r_hold_vld <= '0;
         r_head     <= '0;
         r_tail     <= AW'(1);
         r_count    <= CW'(1);
         r_push_ptr <= '0;
         r_disp_ptr <= '0;
         r_pc_valid <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_pc_valid <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            r_state[i] <= w_state_d[i];
            if (queue_wen[i]) begin
               if (r_hold_vld[i] && !(w_drain && (w_drn_idx == PW'(i)))) begin
                  r_overflow <= 1'b1;
               end else begin
                  r_hold_vld[i] <= 1'b1;
                  r_hold_id[i]  <= queue_number[i*QN_W +: QN_W];
               end
            end else if (w_drain && (w_drn_idx == PW'(i))) begin
               r_hold_vld[i] <= 1'b0;
            end
         end
         if (w_drain) begin
            r_mem[r_tail] <= r_hold_id[w_drn_idx];
            r_tail        <= r_tail + AW'(1);
            r_push_ptr    <= rr_next(w_drn_idx);
         end
         if (w_pop) begin
            r_head                <= r_head + AW'(1);
            r_disp_ptr            <= rr_next(w_pop_idx);
            r_pc_valid[w_pop_idx] <= 1'b1;
            r_new_pc[w_pop_idx]   <= w_start_pc;
         end
         if (w_drain && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_drain && w_pop) r_count <= r_count - CW'(1);
         if (w_all_done) r_done <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_out
      assign new_pc[g*PC_W +: PC_W] = r_new_pc[g];
      assign idle[g*2 +: 2]         = r_state[g];
   end

   assign pc_valid   = r_pc_valid;
   assign done       = r_done;
   assign overflow   = r_overflow;
   assign task_count = r_count;

endmodule

// File: tb/tb_task_scheduler.sv
// Directed bench for task_scheduler: boot, push/pop, full FIFO with overflow, completion,
// asynchronous reset mid-dispatch and dispatch contention.
module tb_task_scheduler;

   logic        clk;
   logic        rst;
   logic [3:0]  request_new_pc;
   logic [3:0]  queue_wen;
   logic [15:0] queue_number;
   logic [63:0] new_pc;
   logic [3:0]  pc_valid;
   logic [7:0]  idle;
   logic        done;
   logic        overflow;
   logic [4:0]  task_count;

   int n_checks;
   int n_fail;

   task_scheduler #(
      .NUM_CORES  (4),
      .QUEUE_DEPTH(16),
      .QN_W       (4),
      .PC_W       (16),
      .PC_SHIFT   (8)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .request_new_pc(request_new_pc),
      .queue_wen     (queue_wen),
      .queue_number  (queue_number),
      .new_pc        (new_pc),
      .pc_valid      (pc_valid),
      .idle          (idle),
      .done          (done),
      .overflow      (overflow),
      .task_count    (task_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pc_of(input int i);
      return 32'(new_pc[i*16 +: 16]);
   endfunction

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst            = 1'b1;
      request_new_pc = '0;
      queue_wen      = '0;
      queue_number   = '0;
      tick();
      tick();
      check("rst_count", 32'(task_count), 32'h1);
      check("rst_idle",  32'(idle),       32'h55);
      check("rst_pcv",   32'(pc_valid),   32'h0);
      check("rst_newpc", 32'(new_pc != 64'h0), 32'h0);
      check("rst_done",  32'(done),       32'h0);
      check("rst_ovf",   32'(overflow),   32'h0);

      // Boot: core0 takes the seeded task 0 on the first edge.
      rst = 1'b0;
      tick();
      check("boot_pcv",   32'(pc_valid),   32'h1);
      check("boot_pc0",   pc_of(0),        32'h0);
      check("boot_idle",  32'(idle),       32'h54);
      check("boot_count", 32'(task_count), 32'h0);
      tick();
      check("boot_strobe", 32'(pc_valid), 32'h0);
      check("boot_nodone", 32'(done),     32'h0);

      // Push/pop: core0 pushes id 3, core1 receives 0x0300 two edges later.
      queue_wen = 4'b0001; queue_number = 16'h0003;
      tick();
      queue_wen = '0;
      check("pp_hold",  32'(task_count), 32'h0);
      tick();
      check("pp_drain", 32'(task_count), 32'h1);
      check("pp_nopop", 32'(pc_valid),   32'h0);
      tick();
      check("pp_pcv",   32'(pc_valid),   32'h2);
      check("pp_pc1",   pc_of(1),        32'h0300);
      check("pp_count", 32'(task_count), 32'h0);
      check("pp_idle",  32'(idle),       32'h50);

      // Back-to-back pushes from core0 feed waiting cores 2 then 3.
      queue_wen = 4'b0001; queue_number = 16'h0007;
      tick();
      queue_number = 16'h0008;
      tick();
      queue_wen = '0;
      tick();
      check("feed_pcv2", 32'(pc_valid), 32'h4);
      check("feed_pc2",  pc_of(2),      32'h0700);
      tick();
      check("feed_pcv3", 32'(pc_valid),   32'h8);
      check("feed_pc3",  pc_of(3),        32'h0800);
      check("feed_cnt",  32'(task_count), 32'h0);
      check("feed_idle", 32'(idle),       32'h00);

      // Fill FIFO with ids F..0 while every core runs.
      for (int k = 0; k < 16; k++) begin
         queue_wen = 4'b0001; queue_number = 16'(15 - k);
         tick();
      end
      queue_wen = '0;
      tick();
      check("full_count", 32'(task_count), 32'h10);

      queue_wen = 4'b1111; queue_number = 16'hDCBA;
      tick();
      queue_wen = '0;
      check("full_noovf", 32'(overflow),   32'h0);
      check("full_cnt1",  32'(task_count), 32'h10);
      tick();
      check("full_cnt2",  32'(task_count), 32'h10);
      queue_wen = 4'b0001; queue_number = 16'h000E;
      tick();
      queue_wen = '0;
      check("full_ovf", 32'(overflow), 32'h1);

      // One pop while full: exactly one hold refills the freed slot.
      request_new_pc = 4'b0001;
      tick();
      request_new_pc = '0;
      check("full_wait", 32'(idle), 32'h01);
      tick();
      check("full_pcv",  32'(pc_valid),   32'h1);
      check("full_pc0",  pc_of(0),        32'h0F00);
      check("full_cnt3", 32'(task_count), 32'h10);

      // Drain the remaining 19 tasks through core0; id A (core0's hold) comes last.
      for (int n = 0; n < 19; n++) begin
         request_new_pc = 4'b0001;
         tick();
         request_new_pc = '0;
         tick();
      end
      check("drain_pc0",  pc_of(0),        32'h0A00);
      check("drain_pcv",  32'(pc_valid),   32'h1);
      check("drain_cnt",  32'(task_count), 32'h0);
      check("drain_ovf",  32'(overflow),   32'h1);

      // Completion.
      request_new_pc = 4'b1111;
      tick();
      request_new_pc = '0;
      check("cmp_notyet", 32'(done), 32'h0);
      check("cmp_wait",   32'(idle), 32'h55);
      tick();
      check("cmp_done", 32'(done), 32'h1);
      check("cmp_idle", 32'(idle), 32'hAA);
      request_new_pc = 4'b1111;
      tick();
      request_new_pc = '0;
      tick();
      check("cmp_term_idle", 32'(idle),     32'hAA);
      check("cmp_term_done", 32'(done),     32'h1);
      check("cmp_term_pcv",  32'(pc_valid), 32'h0);

      // Reset clears sticky state, then async reset lands while pc_valid is high.
      rst = 1'b1;
      tick();
      check("rst2_done",  32'(done),       32'h0);
      check("rst2_ovf",   32'(overflow),   32'h0);
      check("rst2_count", 32'(task_count), 32'h1);
      rst = 1'b0;
      tick();
      check("rst2_boot_pcv", 32'(pc_valid), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("arst_pcv",   32'(pc_valid),   32'h0);
      check("arst_count", 32'(task_count), 32'h1);
      check("arst_idle",  32'(idle),       32'h55);
      tick();
      rst = 1'b0;
      tick();
      check("reboot_pcv",   32'(pc_valid),   32'h1);
      check("reboot_pc0",   pc_of(0),        32'h0);
      check("reboot_idle",  32'(idle),       32'h54);
      check("reboot_count", 32'(task_count), 32'h0);

      // Contention: ids 5,6 pushed together, cores 1..3 waiting.
      queue_wen = 4'b0011; queue_number = 16'h0065;
      tick();
      queue_wen = '0;
      check("ct_pcv0", 32'(pc_valid), 32'h0);
      tick();
      check("ct_cnt1", 32'(task_count), 32'h1);
      tick();
      check("ct_pcv1", 32'(pc_valid), 32'h2);
      check("ct_pc1",  pc_of(1),      32'h0500);
      tick();
      check("ct_pcv2", 32'(pc_valid),   32'h4);
      check("ct_pc2",  pc_of(2),        32'h0600);
      check("ct_cnt0", 32'(task_count), 32'h0);
      check("ct_idle", 32'(idle),       32'h40);
      request_new_pc = 4'b1000;
      tick();
      request_new_pc = '0;
      check("ct_wait_ignored", 32'(idle), 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
